// File: rtl/seq_det_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_arb_pkg
// Description : Shared types and constants for the sequence-detector front
//               end: FSM state encoding, default frame length and the
//               requester id constants.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_arb_pkg;

    // IDLE : detector held in reset, waiting for a frame
    // SHIFT: frame bits are driven onto the detector input
    // RESP : verdict presented; detector held in reset; next frame may start
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int   c_FRAME_LEN = 4;
    localparam logic c_REQ0      = 1'b0;
    localparam logic c_REQ1      = 1'b1;

endpackage
`default_nettype wire

// File: rtl/seq_det_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin grant. A lone requester always wins;
//               on a tie the requester that did not win last time is chosen.
// Ports       : valid0, valid1  - request lines
//               last_grant      - id of the most recently accepted requester
//               enable          - grants are only issued while high
//               grant_vld       - a grant is issued this cycle
//               grant_id        - id of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import seq_det_arb_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    input  logic enable,
    output logic grant_vld,
    output logic grant_id
);

    logic w_both;

    assign w_both    = valid0 & valid1;
    assign grant_vld = enable & (valid0 | valid1);
    assign grant_id  = w_both ? ~last_grant : (valid1 ? c_REQ1 : c_REQ0);

endmodule
`default_nettype wire

// File: rtl/seq_det_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_arbiter
// Description : Two-requester front end for a Mealy sequence detector.
//               Accepts 4-bit frames over valid/ready, arbitrates round-robin,
//               shifts the granted frame LSB-first into the detector, keeps
//               the detector in reset between frames and returns the verdict
//               sampled on the last bit, tagged with the requester id.
// Ports       : clk, rst (async, active-high)
//               req0_valid/req0_frame/req0_ready, req1_* - frame handshakes
//               det_in, det_rst_n (registered), det_dec  - detector link
//               rsp_valid, rsp_id, rsp_dec               - verdict pulse
//               busy                                     - high in SHIFT
//               match_cnt0/match_cnt1 - saturating match counters, present
//               only when SEQ_DET_ARB_MATCH_CNT_EN is defined
// Options     : SEQ_DET_ARB_MATCH_CNT_EN - enables the match counters
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_arbiter
    import seq_det_arb_pkg::*;
#(
    parameter int FRAME_LEN = c_FRAME_LEN,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [FRAME_LEN-1:0] req0_frame,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [FRAME_LEN-1:0] req1_frame,
    output logic                 req1_ready,
    output logic                 det_in,
    output logic                 det_rst_n,
    input  logic                 det_dec,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic                 rsp_dec,
    output logic                 busy
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]     match_cnt0,
    output logic [CNT_W-1:0]     match_cnt1
`endif
);

    localparam int                    c_CNT_BITS = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [c_CNT_BITS-1:0] c_LAST_BIT = c_CNT_BITS'(FRAME_LEN - 1);

    if (FRAME_LEN < 2 || CNT_W < 1) begin : g_param_check
        $error("seq_det_arbiter: FRAME_LEN must be >= 2 and CNT_W >= 1");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [FRAME_LEN-1:0]  r_shreg;
    logic [c_CNT_BITS-1:0] r_bit_cnt;
    logic                  r_grant_id;
    logic                  r_last_grant;
    logic                  r_det_rst_n;
    logic                  r_rsp_id;
    logic                  r_rsp_dec;
    logic                  w_accept_en;
    logic                  w_grant_vld;
    logic                  w_grant_id;
    logic                  w_last_bit;

    // Grants are suppressed while rst is asserted so ready reads low during reset.
    assign w_accept_en = ~rst & ((r_state == IDLE) | (r_state == RESP));

    rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (r_last_grant),
        .enable     (w_accept_en),
        .grant_vld  (w_grant_vld),
        .grant_id   (w_grant_id)
    );

    assign w_last_bit = (r_bit_cnt == c_LAST_BIT);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        det_in      = 1'b0;
        busy        = 1'b0;
        rsp_valid   = 1'b0;

        // The RESP cycle is also an accept cycle, giving FRAME_LEN+1 throughput.
        req0_ready = w_grant_vld & (w_grant_id == c_REQ0);
        req1_ready = w_grant_vld & (w_grant_id == c_REQ1);

        case (r_state)
            IDLE: begin
                if (w_grant_vld) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy   = 1'b1;
                det_in = r_shreg[0];
                if (w_last_bit) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid   = 1'b1;
                w_state_nxt = w_grant_vld ? SHIFT : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: frame capture, serialisation and verdict capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_grant_id   <= c_REQ0;
            r_last_grant <= c_REQ1;  // requester 0 wins the first tie
            r_det_rst_n  <= 1'b0;
            r_rsp_id     <= c_REQ0;
            r_rsp_dec    <= 1'b0;
        end else begin
            // Detector reset follows the state being entered, so it releases
            // exactly on the first shifted bit and re-asserts in RESP.
            r_det_rst_n <= (w_state_nxt == SHIFT);

            if (w_grant_vld) begin
                r_shreg      <= (w_grant_id == c_REQ1) ? req1_frame : req0_frame;
                r_bit_cnt    <= '0;
                r_grant_id   <= w_grant_id;
                r_last_grant <= w_grant_id;
            end else if (r_state == SHIFT) begin
                if (w_last_bit) begin
                    // Mealy output is valid while the last bit is on det_in.
                    r_rsp_dec <= det_dec;
                    r_rsp_id  <= r_grant_id;
                end else begin
                    r_shreg   <= {1'b0, r_shreg[FRAME_LEN-1:1]};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    assign det_rst_n = r_det_rst_n;
    assign rsp_id    = r_rsp_id;
    assign rsp_dec   = r_rsp_dec;

`ifdef SEQ_DET_ARB_MATCH_CNT_EN
    // ------------------------------------------------------------------------
    // Per-requester saturating match counters
    // ------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [CNT_W-1:0] r_match_cnt0;
    logic [CNT_W-1:0] r_match_cnt1;
    logic             w_hit;

    assign w_hit = (r_state == RESP) & r_rsp_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match_cnt0 <= '0;
            r_match_cnt1 <= '0;
        end else if (w_hit) begin
            if (r_rsp_id == c_REQ0 && r_match_cnt0 != c_CNT_MAX) begin
                r_match_cnt0 <= r_match_cnt0 + 1'b1;
            end
            if (r_rsp_id == c_REQ1 && r_match_cnt1 != c_CNT_MAX) begin
                r_match_cnt1 <= r_match_cnt1 + 1'b1;
            end
        end
    end

    assign match_cnt0 = r_match_cnt0;
    assign match_cnt1 = r_match_cnt1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_det_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_arbiter
// Description : Self-checking bench for seq_det_arbiter. A behavioural
//               detector drives det_dec; a transaction-level model predicts
//               handshakes, serial bits and verdicts every cycle.
// Options     : SEQ_DET_ARB_MATCH_CNT_EN - also checks the match counters
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_arbiter;

    localparam int FL = 4;
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 8;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0;
    logic [FL-1:0] req0_frame = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [FL-1:0] req1_frame = '0;
    logic          req1_ready;
    logic          det_in;
    logic          det_rst_n;
    logic          det_dec;
    logic          rsp_valid;
    logic          rsp_id;
    logic          rsp_dec;
    logic          busy;
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
    logic [CW-1:0] match_cnt0;
    logic [CW-1:0] match_cnt1;
`endif

    always #5 clk = ~clk;

    seq_det_arbiter #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_frame (req0_frame),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_frame (req1_frame),
        .req1_ready (req1_ready),
        .det_in     (det_in),
        .det_rst_n  (det_rst_n),
        .det_dec    (det_dec),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_dec    (rsp_dec),
        .busy       (busy)
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
        ,
        .match_cnt0 (match_cnt0),
        .match_cnt1 (match_cnt1)
`endif
    );

    // Frames recognised by the detector, as {bit3,bit2,bit1,bit0}.
    function automatic logic is_match(input logic [3:0] f);
        return (f == 4'b1011) || (f == 4'b0011) || (f == 4'b1010);
    endfunction

    // Behavioural detector: collects bits since its reset, Mealy output on
    // the 4th bit while that bit is still on det_in.
    logic [2:0] d_cnt;
    logic [2:0] d_bits;
    always @(posedge clk) begin
        if (rst || !det_rst_n) begin
            d_cnt  <= 3'd0;
            d_bits <= 3'd0;
        end else if (d_cnt < 3'd4) begin
            if (d_cnt < 3'd3) d_bits[d_cnt[1:0]] <= det_in;
            d_cnt <= d_cnt + 3'd1;
        end
    end
    assign det_dec = (d_cnt == 3'd3) && is_match({det_in, d_bits});

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cycle %0d got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic chkc(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    // m_age: 0 = no frame in flight; 1..FL = cycle carrying frame bit m_age-1;
    // FL+1 = response cycle.
    int         m_age  = 0;
    logic [3:0] m_frame = '0;
    logic       m_id   = 1'b0;
    logic       m_last = 1'b1;
    int         m_cnt [2] = '{0, 0};

    logic acc0, acc1;
    logic obs_rsp_valid, obs_rsp_id, obs_rsp_dec, obs_det_in, obs_det_rst_n;

    task automatic step(input logic v0, input logic [3:0] f0,
                        input logic v1, input logic [3:0] f1);
        logic allow, any, gid, shifting, resp;
        @(negedge clk);
        req0_valid = v0; req0_frame = f0;
        req1_valid = v1; req1_frame = f1;
        #1;
        allow    = (m_age == 0) || (m_age == FL + 1);
        any      = v0 | v1;
        gid      = (v0 && v1) ? ~m_last : v1;
        shifting = (m_age >= 1) && (m_age <= FL);
        resp     = (m_age == FL + 1);
        acc0     = allow && any && !gid;
        acc1     = allow && any && gid;

        chk1("req0_ready", req0_ready, acc0);
        chk1("req1_ready", req1_ready, acc1);
        chk1("det_rst_n", det_rst_n, shifting);
        chk1("busy", busy, shifting);
        chk1("rsp_valid", rsp_valid, resp);
        if (shifting) chk1("det_in", det_in, m_frame[m_age - 1]);
        if (resp) begin
            chk1("rsp_id", rsp_id, m_id);
            chk1("rsp_dec", rsp_dec, is_match(m_frame));
        end
`ifdef SEQ_DET_ARB_MATCH_CNT_EN
        chkc("match_cnt0", match_cnt0, CW'(m_cnt[0]));
        chkc("match_cnt1", match_cnt1, CW'(m_cnt[1]));
`endif
        obs_rsp_valid = rsp_valid; obs_rsp_id = rsp_id; obs_rsp_dec = rsp_dec;
        obs_det_in    = det_in;    obs_det_rst_n = det_rst_n;

        // Advance the model across the coming clock edge.
        if (resp && is_match(m_frame) && m_cnt[m_id] < (1 << CW) - 1) m_cnt[m_id]++;
        if (allow && any) begin
            m_frame = gid ? f1 : f0;
            m_id    = gid;
            m_last  = gid;
            m_age   = 1;
        end else if (resp) begin
            m_age = 0;
        end else if (m_age != 0) begin
            m_age++;
        end
        cyc++;
    endtask

    // Assert reset mid-cycle (with both valids high) and check reset values.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk1("reset det_rst_n", det_rst_n, 1'b0);
        chk1("reset det_in", det_in, 1'b0);
        chk1("reset rsp_valid", rsp_valid, 1'b0);
        chk1("reset rsp_id", rsp_id, 1'b0);
        chk1("reset rsp_dec", rsp_dec, 1'b0);
        chk1("reset busy", busy, 1'b0);
        chk1("reset req0_ready", req0_ready, 1'b0);
        chk1("reset req1_ready", req1_ready, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        m_age = 0; m_last = 1'b1; m_cnt[0] = 0; m_cnt[1] = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One uncontended frame: accept cycle then FL+1 idle cycles.
    task automatic run_frame(input logic id, input logic [3:0] f,
                             output logic got_v, output logic got_id,
                             output logic got_dec, output logic [3:0] bits);
        step(!id, f, id, f);
        for (int k = 0; k < FL; k++) begin
            step(1'b0, 4'd0, 1'b0, 4'd0);
            bits[k] = obs_det_in;
        end
        step(1'b0, 4'd0, 1'b0, 4'd0);
        got_v = obs_rsp_valid; got_id = obs_rsp_id; got_dec = obs_rsp_dec;
    endtask

    typedef struct {
        logic [3:0] frame;
        logic       req;
        logic       exp_dec;
    } vec_t;

    vec_t       tbl [16];
    logic [15:0] dec_mask;
    logic        gv, gid_o, gdec;
    logic [3:0]  gbits;
    logic        p0, p1;
    logic [3:0]  pf0, pf1, sf0, sf1;
    int          rsp_cnt, last_rsp_cyc;
    logic        exp_sid;
    int          exp_cnt [5];

    initial begin
        // Verdict table: 0011, 1010 and 1011 are the only matches.
        dec_mask = 16'h0C08;
        for (int i = 0; i < 16; i++) begin
            tbl[i].frame   = 4'(i);
            tbl[i].req     = i[0];
            tbl[i].exp_dec = dec_mask[i];
        end

        do_reset();

        // ---- all 16 frames, alternating requesters ----
        for (int i = 0; i < 16; i++) begin
            run_frame(tbl[i].req, tbl[i].frame, gv, gid_o, gdec, gbits);
            chk1("tbl rsp_valid", gv, 1'b1);
            chk1("tbl rsp_id", gid_o, tbl[i].req);
            chk1("tbl rsp_dec", gdec, tbl[i].exp_dec);
            chki("tbl det_in bits", int'(gbits), int'(tbl[i].frame));
        end

        // ---- tie right after reset: req0 wins, req1 follows in RESP ----
        do_reset();
        step(1'b1, 4'b0011, 1'b1, 4'b0100);
        chk1("tie first grant req0", acc0, 1'b1);
        for (int k = 0; k < FL + 1; k++) step(1'b0, 4'd0, 1'b1, 4'b0100);
        chk1("tie rsp0 valid", obs_rsp_valid, 1'b1);
        chk1("tie rsp0 id", obs_rsp_id, 1'b0);
        chk1("tie rsp0 dec", obs_rsp_dec, 1'b1);
        chk1("tie req1 accepted in RESP", acc1, 1'b1);
        for (int k = 0; k < FL + 1; k++) step(1'b0, 4'd0, 1'b0, 4'd0);
        chk1("tie rsp1 valid", obs_rsp_valid, 1'b1);
        chk1("tie rsp1 id", obs_rsp_id, 1'b1);
        chk1("tie rsp1 dec", obs_rsp_dec, 1'b0);

        // ---- sustained contention: alternating grants, 5-cycle spacing ----
        step(1'b0, 4'd0, 1'b0, 4'd0);
        sf0 = 4'b1011; sf1 = 4'b0011;
        rsp_cnt = 0; last_rsp_cyc = -1; exp_sid = 1'b0;
        for (int i = 0; i < 80 && rsp_cnt < 10; i++) begin
            step(1'b1, sf0, 1'b1, sf1);
            if (acc0) sf0 = 4'($urandom);
            if (acc1) sf1 = 4'($urandom);
            if (obs_rsp_valid) begin
                chk1("sustain rsp_id", obs_rsp_id, exp_sid);
                chk1("sustain det_rst_n in RESP", obs_det_rst_n, 1'b0);
                if (last_rsp_cyc >= 0) chki("sustain spacing", cyc - last_rsp_cyc, FL + 1);
                last_rsp_cyc = cyc;
                exp_sid = ~exp_sid;
                rsp_cnt++;
            end
        end
        chki("sustain responses", rsp_cnt, 10);
        for (int k = 0; k < FL + 2; k++) step(1'b0, 4'd0, 1'b0, 4'd0);

        // ---- reset during the 2nd SHIFT cycle aborts the frame ----
        step(1'b1, 4'b1011, 1'b0, 4'd0);
        step(1'b0, 4'd0, 1'b0, 4'd0);
        do_reset();
        for (int k = 0; k < FL + 2; k++) step(1'b0, 4'd0, 1'b0, 4'd0);
        run_frame(1'b0, 4'b1011, gv, gid_o, gdec, gbits);
        chk1("resubmit rsp_valid", gv, 1'b1);
        chk1("resubmit rsp_dec", gdec, 1'b1);

        // ---- idle gap between two req1 frames ----
        run_frame(1'b1, 4'b1010, gv, gid_o, gdec, gbits);
        chk1("gap rsp1 dec", gv & gdec, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'd0, 1'b0, 4'd0);
            chk1("gap det_rst_n low", obs_det_rst_n, 1'b0);
        end
        run_frame(1'b1, 4'b1011, gv, gid_o, gdec, gbits);
        chk1("gap rsp2 dec", gv & gdec, 1'b1);
        chk1("gap rsp2 id", gid_o, 1'b1);

        // ---- randomized traffic; requests stay pending until accepted ----
        p0 = 1'b0; p1 = 1'b0; pf0 = '0; pf1 = '0;
        for (int i = 0; i < 600; i++) begin
            if (!p0 && $urandom_range(0, 2) == 0) begin p0 = 1'b1; pf0 = 4'($urandom); end
            if (!p1 && $urandom_range(0, 2) == 0) begin p1 = 1'b1; pf1 = 4'($urandom); end
            step(p0, p0 ? pf0 : 4'($urandom), p1, p1 ? pf1 : 4'($urandom));
            if (acc0) p0 = 1'b0;
            if (acc1) p1 = 1'b0;
        end
        for (int k = 0; k < FL + 2; k++) step(1'b0, 4'd0, 1'b0, 4'd0);

`ifdef SEQ_DET_ARB_MATCH_CNT_EN
        // ---- counters saturate at 3 with CNT_W=2 ----
        exp_cnt = '{1, 2, 3, 3, 3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_frame(1'b0, 4'b1011, gv, gid_o, gdec, gbits);
            step(1'b0, 4'd0, 1'b0, 4'd0);
            chki("cnt0 sequence", int'(match_cnt0), exp_cnt[i]);
            chki("cnt1 stays zero", int'(match_cnt1), 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_det_arbiter.md
# seq_det_arbiter

Two-requester front end for the shared Mealy sequence detector. Each requester submits a 4-bit frame through a valid/ready handshake. The block does four things:
- arbitrates round-robin between the two requesters,
- serializes the granted frame LSB-first into the detector's serial input,
- holds the detector in reset between frames, so every frame starts from the detector's initial state,
- returns the detector's 4th-bit verdict, tagged with the requester id.

## Interface
Parameters:
- FRAME_LEN, 4, bits per frame; sets the shift-register and bit-counter widths.
- CNT_W, 8, width of the per-requester match counters (used only with the counter feature).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a frame.
- req0_frame  in  FRAME_LEN  frame from requester 0; bit 0 is sent first.
- req0_ready  out  1  requester 0 frame accepted this cycle (valid & ready).
- req1_valid, req1_frame, req1_ready  same as requester 0, for requester 1.
- det_in  out  1  serial bit to the detector `in`.
- det_rst_n  out  1  active-low detector reset; registered.
- det_dec  in  1  detector `dec` output (Mealy; valid during the last bit).
- rsp_valid  out  1  one-cycle pulse; the verdict is available.
- rsp_id  out  1  requester that owns the verdict.
- rsp_dec  out  1  detector verdict for the frame.
- busy  out  1  high while in SHIFT.
- match_cnt0, match_cnt1  out  CNT_W  saturating match counts (present only with `SEQ_DET_ARB_MATCH_CNT_EN`).

## Operation
States:
- IDLE: det_rst_n=0.
- SHIFT: det_rst_n=1; det_in=shreg[0].
- RESP: det_rst_n=0; rsp_valid=1.

Transitions:
- IDLE or RESP → SHIFT when any req*_valid is high: the frame is accepted and latched into shreg, bit_cnt=0, grant_id is stored.
- RESP → IDLE when no requester is valid.
- SHIFT → RESP when bit_cnt==FRAME_LEN-1: det_dec is sampled into rsp_dec on that edge. Otherwise shreg shifts right and bit_cnt increments.

Arbitration:
- Requests are accepted only in IDLE or RESP.
- If exactly one requester is valid, it is granted.
- If both are valid, the grant goes to the requester other than last_grant.
- req*_ready is combinational and goes high only for the granted requester, and only in IDLE/RESP.
- last_grant updates on acceptance.

Other rules:
- A req*_valid that is not granted must remain pending; the block never drops a request.
- Frames are not buffered. A frame is captured only on the accept edge, and later changes to req*_frame are ignored.

Reset values (async, all outputs):
- det_rst_n=0, det_in=0.
- rsp_valid=0, rsp_id=0, rsp_dec=0.
- busy=0, req*_ready=0.
- state=IDLE, last_grant=1, so requester 0 wins the first tie.
- counters=0.

Reset asserted in the middle of SHIFT aborts the frame. No rsp_valid is issued for it, and the requester must resubmit.

## Timing
- Accept edge T (valid&ready sampled high). Cycles T+1..T+4 carry det_in = frame[0..3] with det_rst_n=1.
- det_dec is sampled at the edge that ends cycle T+4. rsp_valid, rsp_id and rsp_dec are high during cycle T+5 only.
- Back-to-back throughput is 1 frame per FRAME_LEN+1 cycles. The RESP cycle doubles as the detector-reset cycle and the next accept cycle.
- det_rst_n is low for at least one full cycle between any two frames.
- Request-to-response latency with no contention is FRAME_LEN+1 cycles. Worst case under contention is 2·(FRAME_LEN+1).

## Configuration
- `SEQ_DET_ARB_MATCH_CNT_EN` defined:
  - match_cnt0 and match_cnt1 exist.
  - The counter for rsp_id increments on each RESP cycle with rsp_dec=1.
  - Counters saturate at 2^CNT_W−1 and clear only on rst.
- Not defined: the counter ports and their logic are absent. All other behaviour is identical.

## Structure
- Package `seq_det_arb_pkg` holds:
  - the state encoding (IDLE=2'd0, SHIFT=2'd1, RESP=2'd2),
  - the default FRAME_LEN,
  - the requester id constants REQ0=1'b0 and REQ1=1'b1.
- Sub-module `rr_arb2`: a two-input round-robin grant with inputs (valid0, valid1, last_grant, enable) and outputs (grant_vld, grant_id). The top instantiates it once.

## Test plan
- Single frame: req0 sends 4'b1011 at T → det_in = 1,1,0,1 over T+1..T+4; rsp_valid at T+5 with rsp_id=0, rsp_dec=1. Repeat for all 16 frames: rsp_dec=1 only for 1011, 0011 and 1010.
- Tie: both valid at reset exit, req0=4'b0011 and req1=4'b0100 → req0 is granted first (rsp_dec=1). req1 is accepted in req0's RESP cycle and its response arrives 5 cycles later with rsp_id=1, rsp_dec=0.
- Sustained contention: both valid continuously for 10 frames → grants alternate 0,1,0,1…. Each rsp_valid is exactly 5 cycles apart, and det_rst_n is low in each RESP cycle.
- Reset mid-frame: assert rst during the 2nd SHIFT cycle → det_rst_n=0, state IDLE, no rsp_valid. The resubmitted frame completes normally.
- Idle gaps: req1 sends 1010, then 3 idle cycles, then 1011 → det_rst_n is held low throughout the gap, and both verdicts are 1.
- With `SEQ_DET_ARB_MATCH_CNT_EN` and CNT_W=2: req0 sends 1011 five times → match_cnt0 reads 1,2,3,3,3 and match_cnt1 stays 0.
